// File: rtl/uart_arb_pkg.sv
// uart_arb_pkg -- shared constants for the UART transmit arbiter.
//   NREQ_DEF / DATA_W_DEF : default requester count and byte width
//   ST_IDLE / ST_SEND / ST_HOLD : FSM state encoding
//   owner_w()  : width of a requester index (at least 1 bit)
//   OWNER_W    : owner index width for the default requester count
package uart_arb_pkg;

  localparam int NREQ_DEF   = 4;
  localparam int DATA_W_DEF = 8;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_SEND = 2'd1;
  localparam logic [1:0] ST_HOLD = 2'd2;

  function automatic int owner_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int OWNER_W = owner_w(NREQ_DEF);

endpackage

// File: rtl/uart_arb_rr_pick.sv
// uart_arb_rr_pick -- combinational round-robin selector.
//   req         : per-requester pending bits
//   pointer     : index of the last granted requester
//   grant_valid : at least one request is pending
//   grant_idx   : first pending index searching upward from pointer+1,
//                 wrapping around modulo NREQ
module uart_arb_rr_pick
  import uart_arb_pkg::*;
#(
  parameter int NREQ = NREQ_DEF,
  localparam int OW  = owner_w(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [OW-1:0]   pointer,
  output logic            grant_valid,
  output logic [OW-1:0]   grant_idx
);

  // Walk the candidates from farthest to nearest so the nearest pending
  // requester after the pointer is the last one written and therefore wins.
  always_comb begin
    logic [OW-1:0] idx;
    grant_valid = 1'b0;
    grant_idx   = '0;
    idx         = '0;
    for (int i = NREQ; i >= 1; i--) begin
      idx = OW'((int'(pointer) + i) % NREQ);
      if (req[idx]) begin
        grant_valid = 1'b1;
        grant_idx   = idx;
      end else begin
        grant_idx   = grant_idx;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter -- round-robin arbiter sharing one UART transmitter
// between NREQ byte sources. All outputs are registered.
//   clk, reset        : clock, synchronous active-high reset
//   req / req_data    : per-requester pending flag and byte
//   ack / done        : one-hot pulses on byte acceptance / completion
//   owner, busy       : current/last granted index, arbiter not idle
//   tx_start, tx_data : transmitter start pulse and byte
//   tx_busy, tx_end   : transmitter busy level and finished pulse
//   lock              : per-requester hold request; present only when
//                       the macro UART_ARB_LOCK_EN is defined, which
//                       also enables the HOLD state
module uart_tx_arbiter
  import uart_arb_pkg::*;
#(
  parameter int NREQ   = NREQ_DEF,
  parameter int DATA_W = DATA_W_DEF,
  localparam int OW    = owner_w(NREQ)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NREQ-1:0]        req,
  input  logic [NREQ*DATA_W-1:0] req_data,
  output logic [NREQ-1:0]        ack,
  output logic [NREQ-1:0]        done,
  output logic [OW-1:0]          owner,
  output logic                   busy,
  output logic                   tx_start,
  output logic [DATA_W-1:0]      tx_data,
  input  logic                   tx_busy,
`ifdef UART_ARB_LOCK_EN
  input  logic [NREQ-1:0]        lock,
`endif
  input  logic                   tx_end
);

  logic [1:0]        state_q, state_d;
  logic [OW-1:0]     last_q, last_d;     // round-robin pointer
  logic [OW-1:0]     owner_q, owner_d;
  logic [NREQ-1:0]   ack_q, ack_d;
  logic [NREQ-1:0]   done_q, done_d;
  logic              busy_q, busy_d;
  logic              tx_start_q, tx_start_d;
  logic [DATA_W-1:0] tx_data_q, tx_data_d;

  logic              pick_valid;
  logic [OW-1:0]     pick_idx;

  uart_arb_rr_pick #(.NREQ(NREQ)) u_pick (
    .req         (req),
    .pointer     (last_q),
    .grant_valid (pick_valid),
    .grant_idx   (pick_idx)
  );

  // Next-state and next-output logic; pulses default low every cycle.
  always_comb begin
    state_d    = state_q;
    last_d     = last_q;
    owner_d    = owner_q;
    tx_data_d  = tx_data_q;
    tx_start_d = 1'b0;
    ack_d      = '0;
    done_d     = '0;
    case (state_q)
      ST_IDLE: begin
        if (pick_valid && !tx_busy) begin
          tx_start_d      = 1'b1;
          tx_data_d       = req_data[pick_idx*DATA_W +: DATA_W];
          ack_d[pick_idx] = 1'b1;
          owner_d         = pick_idx;
          last_d          = pick_idx;
          state_d         = ST_SEND;
        end else begin
          state_d         = ST_IDLE;
        end
      end
      ST_SEND: begin
        // req/req_data are deliberately not looked at while a byte is out.
        if (tx_end) begin
          done_d[owner_q] = 1'b1;
          tx_data_d       = '0;
`ifdef UART_ARB_LOCK_EN
          state_d         = lock[owner_q] ? ST_HOLD : ST_IDLE;
`else
          state_d         = ST_IDLE;
`endif
        end else begin
          state_d         = ST_SEND;
        end
      end
`ifdef UART_ARB_LOCK_EN
      ST_HOLD: begin
        // Releasing the lock takes a cycle of its own; no grant alongside.
        if (!lock[owner_q]) begin
          state_d        = ST_IDLE;
        end else if (req[owner_q] && !tx_busy) begin
          tx_start_d     = 1'b1;
          tx_data_d      = req_data[owner_q*DATA_W +: DATA_W];
          ack_d[owner_q] = 1'b1;
          last_d         = owner_q;
          state_d        = ST_SEND;
        end else begin
          state_d        = ST_HOLD;
        end
      end
`endif
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  // State and output registers; reset points the pointer at NREQ-1 so
  // requester 0 is searched first.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      last_q     <= OW'(NREQ - 1);
      owner_q    <= '0;
      ack_q      <= '0;
      done_q     <= '0;
      busy_q     <= 1'b0;
      tx_start_q <= 1'b0;
      tx_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      last_q     <= last_d;
      owner_q    <= owner_d;
      ack_q      <= ack_d;
      done_q     <= done_d;
      busy_q     <= busy_d;
      tx_start_q <= tx_start_d;
      tx_data_q  <= tx_data_d;
    end
  end

  assign ack      = ack_q;
  assign done     = done_q;
  assign owner    = owner_q;
  assign busy     = busy_q;
  assign tx_start = tx_start_q;
  assign tx_data  = tx_data_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter -- self-checking bench for uart_tx_arbiter.
// A transaction-level model predicts every output after each clock edge;
// directed scenarios add literal expectations. Lock scenario runs only
// when UART_ARB_LOCK_EN is defined.
module tb_uart_tx_arbiter;

  localparam int NREQ   = 4;
  localparam int DATA_W = 8;
`ifdef UART_ARB_LOCK_EN
  localparam bit LOCK_ON = 1'b1;
`else
  localparam bit LOCK_ON = 1'b0;
`endif

  logic                   clk = 1'b0;
  logic                   reset;
  logic [NREQ-1:0]        req;
  logic [NREQ*DATA_W-1:0] req_data;
  logic [NREQ-1:0]        ack;
  logic [NREQ-1:0]        done;
  logic [1:0]             owner;
  logic                   busy;
  logic                   tx_start;
  logic [DATA_W-1:0]      tx_data;
  logic                   tx_busy;
  logic                   tx_end;
  logic [NREQ-1:0]        lock;

  int n_checks = 0;
  int n_fail   = 0;

  // model state
  bit              m_active;
  bit              m_hold;
  int              m_last;
  int              m_owner;
  logic [NREQ-1:0] e_ack, e_done;
  logic            e_start, e_busy;
  logic [7:0]      e_data;

  uart_tx_arbiter #(.NREQ(NREQ), .DATA_W(DATA_W)) dut (
    .clk      (clk),
    .reset    (reset),
    .req      (req),
    .req_data (req_data),
    .ack      (ack),
    .done     (done),
    .owner    (owner),
    .busy     (busy),
    .tx_start (tx_start),
    .tx_data  (tx_data),
    .tx_busy  (tx_busy),
`ifdef UART_ARB_LOCK_EN
    .lock     (lock),
`endif
    .tx_end   (tx_end)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int onehot_idx(input logic [NREQ-1:0] v);
    int r = -1;
    for (int i = 0; i < NREQ; i++) if (v[i]) r = i;
    return r;
  endfunction

  task automatic model_grant(input int w);
    e_start  = 1'b1;
    e_ack    = NREQ'(1) << w;
    e_data   = req_data[w*DATA_W +: DATA_W];
    m_owner  = w;
    m_last   = w;
    m_active = 1'b1;
  endtask

  // Predict the outputs that the next clock edge produces from current inputs.
  task automatic model_step();
    e_start = 1'b0;
    e_ack   = '0;
    e_done  = '0;
    if (reset) begin
      m_active = 1'b0; m_hold = 1'b0; m_last = NREQ - 1; m_owner = 0;
      e_data   = 8'h00;
    end else if (m_active) begin
      if (tx_end) begin
        e_done   = NREQ'(1) << m_owner;
        e_data   = 8'h00;
        m_active = 1'b0;
        m_hold   = LOCK_ON && lock[m_owner];
      end
    end else if (m_hold) begin
      if (!lock[m_owner]) m_hold = 1'b0;
      else if (req[m_owner] && !tx_busy) begin
        m_hold = 1'b0;
        model_grant(m_owner);
      end
    end else if (req != '0 && !tx_busy) begin
      for (int k = 1; k <= NREQ; k++) begin
        if (req[(m_last + k) % NREQ]) begin
          model_grant((m_last + k) % NREQ);
          break;
        end
      end
    end
    e_busy = m_active || m_hold;
  endtask

  // One clock: predict, advance, then compare every output 1 ns after the edge.
  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    check("ack", ack, e_ack);
    check("done", done, e_done);
    check("owner", owner, m_owner);
    check("busy", busy, e_busy);
    check("tx_start", tx_start, e_start);
    check("tx_data", tx_data, e_data);
  endtask

  task automatic finish_byte(input int wait_n);
    repeat (wait_n) tick();
    tx_end = 1'b1;
    tick();
    tx_end = 1'b0;
  endtask

  task automatic wait_grant(output int idx);
    idx = -1;
    for (int k = 0; k < 4; k++) begin
      tick();
      if (tx_start === 1'b1) begin
        idx = onehot_idx(ack);
        break;
      end
    end
    if (idx < 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL grant_timeout: got no tx_start expected a grant at %0t", $time);
    end
  endtask

  initial begin
    int order[5];
    int exp_order[5] = '{0, 1, 2, 3, 0};
    reset = 1'b1; req = '0; req_data = '0; tx_busy = 1'b0; tx_end = 1'b0; lock = '0;
    tick(); tick();
    check("rst_owner", owner, 32'd0);
    check("rst_busy", busy, 32'd0);
    check("rst_tx_data", tx_data, 32'd0);
    reset = 1'b0;

    // single request
    req = 4'b0001; req_data[7:0] = 8'h55;
    tick();
    check("single_start", tx_start, 32'd1);
    check("single_data", tx_data, 32'h55);
    check("single_ack", ack, 32'h1);
    req = '0;
    tick();
    check("single_start_pulse", tx_start, 32'd0);
    check("single_busy", busy, 32'd1);
    finish_byte(1);
    check("single_done", done, 32'h1);
    tick();
    check("single_idle", busy, 32'd0);
    check("single_data_clr", tx_data, 32'd0);
    tx_end = 1'b1;
    tick();
    check("idle_tx_end_done", done, 32'd0);
    tx_end = 1'b0;

    // external busy holds off the grant; SEND ignores req/req_data changes
    tx_busy = 1'b1; req = 4'b0010; req_data[15:8] = 8'hA1;
    repeat (3) begin
      tick();
      check("txbusy_no_start", tx_start, 32'd0);
    end
    tx_busy = 1'b0;
    tick();
    check("txbusy_ack", ack, 32'h2);
    check("txbusy_data", tx_data, 32'hA1);
    req = 4'b0100; req_data[15:8] = 8'h3C;
    tick();
    check("send_hold_data", tx_data, 32'hA1);
    req = '0;
    finish_byte(1);
    tick();

    // fairness from reset
    reset = 1'b1; tick(); reset = 1'b0;
    req = 4'b1111; req_data = 32'hD3C2B1A0;
    for (int g = 0; g < 5; g++) begin
      wait_grant(order[g]);
      finish_byte(9);
    end
    for (int g = 0; g < 5; g++) check("rr_order", order[g], exp_order[g]);
    check("rr_data_last", req_data[7:0], 32'hA0);

    // reset mid-SEND
    req = 4'b0010;
    tick();
    check("mid_ack", ack, 32'h2);
    req = '0;
    repeat (3) tick();
    reset = 1'b1;
    tick();
    check("mid_rst_busy", busy, 32'd0);
    check("mid_rst_data", tx_data, 32'd0);
    check("mid_rst_owner", owner, 32'd0);
    reset = 1'b0; tx_end = 1'b1;
    tick();
    check("mid_no_done", done, 32'd0);
    tx_end = 1'b0; req = 4'b1111;
    tick();
    check("mid_next_grant", ack, 32'h1);
    req = '0;
    finish_byte(2);
    tick();

`ifdef UART_ARB_LOCK_EN
    // lock: three bytes to owner 2, then release goes round-robin to 1
    reset = 1'b1; tick(); reset = 1'b0;
    lock = 4'b0100; req = 4'b0100;
    tick();
    check("lock_g1", ack, 32'h4);
    req = 4'b0110;
    finish_byte(2);
    tick();
    check("lock_g2", ack, 32'h4);
    finish_byte(2);
    tick();
    check("lock_g3", ack, 32'h4);
    finish_byte(2);
    check("lock_hold_busy", busy, 32'd1);
    lock = '0;
    tick();
    check("lock_release_no_start", tx_start, 32'd0);
    tick();
    check("lock_after_release", ack, 32'h2);
    req = '0;
    finish_byte(2);
    tick();
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
